// File: rtl/rf_op_sched.sv
// Two-requester round-robin scheduler sequencing ALU ops through a 16x16 register file.
// Latency: ALU/MOV done 3 cycles after accept, LDI/NOP 1 cycle; ready only pulses while idle.
module rf_op_sched (
   input  logic        clk,
   input  logic        clear,
   input  logic        req0_valid,
   input  logic [2:0]  req0_op,
   input  logic [3:0]  req0_dst,
   input  logic [3:0]  req0_srca,
   input  logic [3:0]  req0_srcb,
   input  logic [15:0] req0_imm,
   input  logic        req1_valid,
   input  logic [2:0]  req1_op,
   input  logic [3:0]  req1_dst,
   input  logic [3:0]  req1_srca,
   input  logic [3:0]  req1_srcb,
   input  logic [15:0] req1_imm,
   output logic        req0_ready,
   output logic        req1_ready,
   output logic [3:0]  rf_Aaddr,
   output logic [3:0]  rf_Baddr,
   output logic        rf_rd,
   input  logic [15:0] rf_A,
   input  logic [15:0] rf_B,
   output logic [3:0]  rf_Caddr,
   output logic [15:0] rf_C,
   output logic        rf_wr,
   output logic        done,
   output logic        done_id,
   output logic [15:0] result,
   output logic        zero
);

   typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} stateT;

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_MOV = 3'd4;
   localparam logic [2:0] OP_LDI = 3'd5;

   stateT       state, nextState;
   logic        ptr;
   logic [2:0]  opR;
   logic [3:0]  dstR;
   logic [15:0] resR;
   logic        idR;

   logic        grantAny, grantId, gNeedsRead, opIsNop;
   logic [2:0]  gOp;
   logic [3:0]  gDst, gSrcA, gSrcB;
   logic [15:0] gImm, aluRes;

   // Pointer names the favoured requester when both are valid.
   always_comb begin
      grantAny   = (state == IDLE) && (req0_valid || req1_valid) && !clear;
      grantId    = req1_valid && (!req0_valid || ptr);
      gOp        = grantId ? req1_op   : req0_op;
      gDst       = grantId ? req1_dst  : req0_dst;
      gSrcA      = grantId ? req1_srca : req0_srca;
      gSrcB      = grantId ? req1_srcb : req0_srcb;
      gImm       = grantId ? req1_imm  : req0_imm;
      gNeedsRead = (gOp <= OP_MOV);
      opIsNop    = (opR[2:1] == 2'b11);
   end

   always_comb begin
      case (opR)
         OP_ADD:  aluRes = rf_A + rf_B;
         OP_SUB:  aluRes = rf_A - rf_B;
         OP_AND:  aluRes = rf_A & rf_B;
         OP_OR:   aluRes = rf_A | rf_B;
         default: aluRes = rf_A;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clear) state <= IDLE;
      else       state <= nextState;
   end

   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (grantAny) nextState = gNeedsRead ? READ : WRITE;
         READ:    nextState = EXEC;
         EXEC:    nextState = WRITE;
         WRITE:   nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Address and write-data registers load only on the way into READ/WRITE, so they hold otherwise.
   always_ff @(posedge clk) begin
      if (clear) begin
         ptr      <= 1'b0;
         opR      <= 3'd0;
         dstR     <= 4'd0;
         resR     <= 16'd0;
         idR      <= 1'b0;
         rf_Aaddr <= 4'd0;
         rf_Baddr <= 4'd0;
         rf_Caddr <= 4'd0;
         rf_C     <= 16'd0;
      end else begin
         if (grantAny) begin
            ptr  <= ~grantId;
            opR  <= gOp;
            dstR <= gDst;
            idR  <= grantId;
            if (gNeedsRead) begin
               rf_Aaddr <= gSrcA;
               rf_Baddr <= gSrcB;
            end else if (gOp == OP_LDI) begin
               resR     <= gImm;
               rf_Caddr <= gDst;
               rf_C     <= gImm;
            end else begin
               resR <= 16'd0;
            end
         end
         if (state == EXEC) begin
            resR     <= aluRes;
            rf_C     <= aluRes;
            rf_Caddr <= dstR;
         end
      end
   end

   always_comb begin
      req0_ready = grantAny && !grantId;
      req1_ready = grantAny && grantId;
      rf_rd      = (state == READ) && !clear;
      done       = (state == WRITE) && !clear;
      rf_wr      = done && !opIsNop;
      done_id    = idR;
      result     = (state == WRITE) ? resR : 16'd0;
      zero       = done && (resR == 16'd0);
   end

endmodule

// File: tb/tb_rf_op_sched.sv
// Bench for rf_op_sched: register-file model, arbitration/timing reference and result scoreboard.
module tb_rf_op_sched;

   logic        clk = 1'b0;
   logic        clear;
   logic        req0_valid, req1_valid;
   logic [2:0]  req0_op, req1_op;
   logic [3:0]  req0_dst, req1_dst, req0_srca, req1_srca, req0_srcb, req1_srcb;
   logic [15:0] req0_imm, req1_imm;
   logic        req0_ready, req1_ready;
   logic [3:0]  rf_Aaddr, rf_Baddr, rf_Caddr;
   logic        rf_rd, rf_wr, done, done_id, zero;
   logic [15:0] rf_A, rf_B, rf_C, result;

   int total = 0;
   int bad   = 0;

   rf_op_sched dut (
      .clk(clk), .clear(clear),
      .req0_valid(req0_valid), .req0_op(req0_op), .req0_dst(req0_dst),
      .req0_srca(req0_srca), .req0_srcb(req0_srcb), .req0_imm(req0_imm),
      .req1_valid(req1_valid), .req1_op(req1_op), .req1_dst(req1_dst),
      .req1_srca(req1_srca), .req1_srcb(req1_srcb), .req1_imm(req1_imm),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .rf_Aaddr(rf_Aaddr), .rf_Baddr(rf_Baddr), .rf_rd(rf_rd),
      .rf_A(rf_A), .rf_B(rf_B),
      .rf_Caddr(rf_Caddr), .rf_C(rf_C), .rf_wr(rf_wr),
      .done(done), .done_id(done_id), .result(result), .zero(zero)
   );

   always #5 clk = ~clk;

   // Register file the DUT talks to: write on rf_wr, read data one cycle after rf_rd.
   logic [15:0] regs [16];
   always @(posedge clk) begin
      if (rf_wr) regs[rf_Caddr] <= rf_C;
      if (rf_rd) begin
         rf_A <= regs[rf_Aaddr];
         rf_B <= regs[rf_Baddr];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] refOp(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] imm);
      int r;
      case (op)
         3'd0:    r = int'(a) + int'(b);
         3'd1:    r = int'(a) - int'(b) + 65536;
         3'd2:    r = int'(a & b);
         3'd3:    r = int'(a | b);
         3'd4:    r = int'(a);
         3'd5:    r = int'(imm);
         default: r = 0;
      endcase
      return r[15:0];
   endfunction

   typedef struct {
      logic        id;
      logic [2:0]  op;
      logic [3:0]  dst, a, b;
      logic [15:0] res;
   } expT;

   expT         sb[$];
   logic [15:0] refRegs [16];
   bit          busy = 0;
   bit          mPtr = 0;
   int          cnt  = 0;

   // Reference: arbitration and cycle timing drawn from the op latencies, results from refRegs.
   always @(negedge clk) begin
      bit   startBusy, expRd, expDone, g;
      logic [1:0] expRdy;
      expT  e;
      if (clear) begin
         chk("clr_ready", {req1_ready, req0_ready}, 2'b00);
         chk("clr_rd", rf_rd, 1'b0);
         chk("clr_wr", rf_wr, 1'b0);
         chk("clr_done", done, 1'b0);
         busy = 0; mPtr = 0; cnt = 0;
         sb.delete();
      end else begin
         startBusy = busy;
         if (busy) cnt--;
         expRd   = busy && (cnt == 2);
         expDone = busy && (cnt == 0);
         chk("rd_strobe", rf_rd, expRd);
         if (expRd && sb.size() > 0) begin
            chk("rd_Aaddr", rf_Aaddr, sb[0].a);
            chk("rd_Baddr", rf_Baddr, sb[0].b);
         end
         chk("done", done, expDone);
         if (done && sb.size() > 0) begin
            e = sb.pop_front();
            chk("done_id", done_id, e.id);
            chk("result", result, e.res);
            chk("zero", zero, e.res == 16'd0);
            chk("wr_strobe", rf_wr, e.op < 3'd6);
            if (e.op < 3'd6) begin
               chk("wr_Caddr", rf_Caddr, e.dst);
               chk("wr_C", rf_C, e.res);
               refRegs[e.dst] = e.res;
            end
         end else begin
            chk("wr_idle", rf_wr, 1'b0);
         end
         if (expDone) busy = 0;

         expRdy = 2'b00;
         if (!startBusy && (req0_valid || req1_valid)) begin
            g = (req0_valid && req1_valid) ? mPtr : req1_valid;
            expRdy[g] = 1'b1;
         end
         chk("ready", {req1_ready, req0_ready}, expRdy);
         if (expRdy != 2'b00) begin
            e.id  = g;
            e.op  = g ? req1_op   : req0_op;
            e.dst = g ? req1_dst  : req0_dst;
            e.a   = g ? req1_srca : req0_srca;
            e.b   = g ? req1_srcb : req0_srcb;
            e.res = refOp(e.op, refRegs[e.a], refRegs[e.b], g ? req1_imm : req0_imm);
            sb.push_back(e);
            busy = 1;
            cnt  = (e.op <= 3'd4) ? 3 : 1;
            mPtr = ~g;
         end
      end
   end

   task automatic issue(input bit id, input logic [2:0] op, input logic [3:0] d,
                        input logic [3:0] a, input logic [3:0] b, input logic [15:0] imm);
      bit got = 0;
      if (id) begin
         req1_valid = 1; req1_op = op; req1_dst = d; req1_srca = a; req1_srcb = b; req1_imm = imm;
      end else begin
         req0_valid = 1; req0_op = op; req0_dst = d; req0_srca = a; req0_srcb = b; req0_imm = imm;
      end
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk);
         got = id ? req1_ready : req0_ready;
      end
      if (!got) begin
         total++; bad++;
         $display("FAIL accept_timeout: requester %0d got no ready, expected one", id);
      end
      @(posedge clk); #1;
      if (id) req1_valid = 0;
      else    req0_valid = 0;
   endtask

   task automatic settle();
      repeat (8) @(posedge clk);
      #1;
   endtask

   task automatic randOps(input bit id, input int num);
      for (int k = 0; k < num; k++) begin
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         issue(id, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 16'($urandom));
      end
   endtask

   initial begin
      for (int i = 0; i < 16; i++) begin
         regs[i] = 16'd0;
         refRegs[i] = 16'd0;
      end
      rf_A = 16'd0; rf_B = 16'd0;
      clear = 1;
      req0_valid = 0; req0_op = 0; req0_dst = 0; req0_srca = 0; req0_srcb = 0; req0_imm = 0;
      req1_valid = 0; req1_op = 0; req1_dst = 0; req1_srca = 0; req1_srcb = 0; req1_imm = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_Aaddr", rf_Aaddr, 4'd0);
      chk("rst_Caddr", rf_Caddr, 4'd0);
      chk("rst_C", rf_C, 16'd0);
      chk("rst_result", result, 16'd0);
      chk("rst_zero", zero, 1'b0);
      @(posedge clk); #1;
      clear = 0;

      issue(0, 3'd5, 4'd3, 4'd0, 4'd0, 16'h1234);
      settle();
      chk("r3_ldi", regs[3], 16'h1234);

      issue(0, 3'd5, 4'd1, 4'd0, 4'd0, 16'hFFFF);
      issue(0, 3'd5, 4'd2, 4'd0, 4'd0, 16'h0002);
      issue(1, 3'd0, 4'd4, 4'd1, 4'd2, 16'h0);
      settle();
      chk("r4_add_wrap", regs[4], 16'h0001);

      issue(0, 3'd5, 4'd5, 4'd0, 4'd0, 16'h00AA);
      issue(0, 3'd5, 4'd6, 4'd0, 4'd0, 16'h00AA);
      issue(0, 3'd5, 4'd8, 4'd0, 4'd0, 16'h0077);
      issue(0, 3'd1, 4'd7, 4'd5, 4'd6, 16'h0);
      issue(1, 3'd4, 4'd8, 4'd7, 4'd0, 16'h0);
      settle();
      chk("r7_sub_zero", regs[7], 16'h0000);
      chk("r8_mov", regs[8], 16'h0000);

      fork
         for (int k = 0; k < 4; k++) issue(0, 3'd0, 4'd10, 4'd1, 4'd2, 16'h0);
         for (int k = 0; k < 4; k++) issue(1, 3'd5, 4'd11, 4'd0, 4'd0, 16'(k));
      join
      settle();

      issue(0, 3'd0, 4'd9, 4'd1, 4'd2, 16'h0);
      @(posedge clk); #1;
      clear = 1;
      @(posedge clk); #1;
      clear = 0;
      fork
         issue(0, 3'd5, 4'd12, 4'd0, 4'd0, 16'h0055);
         issue(1, 3'd5, 4'd13, 4'd0, 4'd0, 16'h0066);
      join
      settle();
      chk("r9_cleared_op", regs[9], 16'h0000);
      chk("r12_after_clear", regs[12], 16'h0055);

      issue(1, 3'd6, 4'd14, 4'd0, 4'd0, 16'hBEEF);
      issue(0, 3'd5, 4'd1, 4'd0, 4'd0, 16'h0003);
      issue(0, 3'd0, 4'd1, 4'd1, 4'd1, 16'h0);
      issue(0, 3'd0, 4'd1, 4'd1, 4'd1, 16'h0);
      settle();
      chk("r14_nop", regs[14], 16'h0000);
      chk("r1_hazard", regs[1], 16'd12);

      fork
         randOps(0, 25);
         randOps(1, 25);
      join
      settle();
      chk("sb_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rf_op_sched.md
# rf_op_sched

Two-requester operation scheduler for the 16x16-bit register file. Accepts register-to-register ALU operations from two requesters, arbitrates round-robin, and sequences each operation through the register file: read the operands, compute, write the result. It drives the register file's address, data and strobe ports and returns each result with a completion pulse.

## Interface
- No parameters: 16-bit data and 4-bit register addresses are fixed.
- clk  in  1  clock; all state changes on rising edge
- clear  in  1  synchronous, active-high reset
- req0_valid, req1_valid  in  1  operation request; held, with its fields, until the matching ready pulse
- req0_op, req1_op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MOV (dst=srca), 101 LDI (dst=imm), 110/111 NOP
- req0_dst, req1_dst  in  4  destination register
- req0_srca, req1_srca / req0_srcb, req1_srcb  in  4  source registers
- req0_imm, req1_imm  in  16  immediate for LDI
- req0_ready, req1_ready  out  1  one-cycle accept pulse
- rf_Aaddr, rf_Baddr  out  4  register file read addresses
- rf_rd  out  1  read strobe; operands appear on rf_A/rf_B the following cycle
- rf_A, rf_B  in  16  register file read data
- rf_Caddr  out  4  write address
- rf_C  out  16  write data
- rf_wr  out  1  write strobe, one cycle
- done  out  1  completion pulse
- done_id  out  1  requester of completed op (0/1)
- result  out  16  value written, or 0 for NOP
- zero  out  1  result == 0, valid with done

## Operation
- States: IDLE, READ, EXEC, WRITE.
- IDLE: if any req valid, grant per arbitration, pulse reqN_ready in the same cycle, latch op/dst/srca/srcb/imm and the grant id.
  - ALU op or MOV -> READ.
  - LDI or NOP -> WRITE. The result register is loaded with imm for LDI and with 0 for NOP.
- READ: rf_rd=1, rf_Aaddr=srca, rf_Baddr=srcb -> EXEC.
- EXEC: capture rf_A/rf_B and compute into the result register -> WRITE.
  - ADD: (A+B) mod 2^16.
  - SUB: (A-B) mod 2^16.
  - AND: A&B.
  - OR: A|B.
  - MOV: A.
  - No carry or overflow outputs.
- WRITE: done=1 with done_id, result, zero. rf_wr=1, rf_Caddr=dst, rf_C=result, except for NOP (rf_wr=0) -> IDLE.
- Arbitration: 1-bit priority pointer, reset 0.
  - Both valid: grant the pointer's requester.
  - One valid: grant it.
  - After every grant, pointer = ~granted id.
- Outside WRITE, rf_C and rf_Caddr hold their last values. Outside READ, rf_Aaddr and rf_Baddr hold their last values.
- dst equal to srca or srcb: the read precedes the write, so old values are used.
- Back-to-back ops read after the prior WRITE cycle, so they see updated values.

## Timing
- ALU/MOV: accept at cycle 0, READ cycle 1, EXEC cycle 2, WRITE/done cycle 3, IDLE cycle 4. Next accept no earlier than cycle 4.
- LDI/NOP: accept at cycle 0, WRITE/done cycle 1, IDLE cycle 2.
- ready is asserted only in IDLE. There is at most one ready per cycle and never both.
- Reset values: state IDLE, pointer 0; all outputs 0.
- clear sampled high: next state IDLE and any in-flight op is discarded, with no later write or done. rf_rd, rf_wr, done and reqN_ready are combinationally gated by !clear, so there is no strobe in the clear cycle.
- A request that drops valid before ready is simply not served.

## Test plan
- Reset then LDI: req0 LDI dst=3 imm=0x1234 -> ready at c0; c1 rf_wr=1, Caddr=3, C=0x1234, done=1, done_id=0, zero=0.
- ADD wrap: preload r1=0xFFFF, r2=0x0002; req1 ADD dst=4 srca=1 srcb=2 -> c1 rf_rd with Aaddr=1/Baddr=2; c3 write r4=0x0001, done_id=1.
- SUB to zero: r5=r6=0x00AA, SUB dst=7 -> result 0x0000, zero=1. Then MOV dst=8 srca=7 -> r8=0.
- Round-robin: both requesters hold valid for 4 ops each -> grants alternate 0,1,0,1,...; ready never coincident; done_id sequence matches.
- Clear mid-op: ADD accepted, clear high in EXEC cycle -> no rf_wr, no done. IDLE next cycle; pointer=0; a new req0 is accepted the cycle after clear drops.
- NOP and hazard: NOP (op 110) -> done=1, result=0, rf_wr=0. ADD dst=1 srca=1 srcb=1 with r1=3 -> r1=6; following ADD same regs -> r1=12.
